// File: rtl/isr_pkg.sv
// Shared definitions for the interrupt service sequencer: FSM state encoding
// and the fixed post-clear settle length.
package isr_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DISPATCH = 3'd1,
        SERVICE  = 3'd2,
        CLEAR    = 3'd3,
        SETTLE   = 3'd4
    } isr_state_t;

    localparam int SETTLE_CYCLES = 2;

endpackage

// File: rtl/interrupt_service_sequencer.sv
// Sequences one interrupt at a time: dispatch vector, wait for handler, clear, settle.
// Optional SERVICE watchdog enabled with `define ISR_TIMEOUT_EN.
module interrupt_service_sequencer
    import isr_pkg::*;
#(
    parameter int NUM_INTERRUPTS = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      service_enable,
    input  logic                      interrupt_request,
    input  logic [NUM_INTERRUPTS-1:0] interrupt_pending,
    input  logic [2:0]                highest_priority_int,
    output logic                      vector_valid,
    output logic [2:0]                vector_id,
    input  logic                      vector_ready,
    input  logic                      handler_done,
    output logic [NUM_INTERRUPTS-1:0] clear_interrupt_select,
    output logic                      service_busy,
    output logic                      timeout_error,
    output logic [15:0]               serviced_count,
    output logic [2:0]                o_dbg_state
);

    if (NUM_INTERRUPTS < 2 || NUM_INTERRUPTS > 8 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("interrupt_service_sequencer: parameter out of range");
    end

    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

    isr_state_t  r_state;
    isr_state_t  w_next_state;
    logic [2:0]  r_vector_id;
    logic [1:0]  r_settle_cnt;
    logic [15:0] r_serviced_count;
    logic [7:0]  w_pending_ext;
    logic        w_start;
    logic        w_vec_pending;
    logic        w_timeout_hit;

    // Lines at or above NUM_INTERRUPTS read as not pending, so a stray ID never starts a service.
    assign w_pending_ext = 8'(interrupt_pending);
    assign w_start       = service_enable && interrupt_request && w_pending_ext[highest_priority_int];
    assign w_vec_pending = w_pending_ext[r_vector_id];

`ifdef ISR_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_timeout_cnt;
    logic        r_timeout_error;

    assign w_timeout_hit = (r_timeout_cnt == TIMEOUT_LAST);
    assign timeout_error = r_timeout_error;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_timeout_cnt   <= '0;
            r_timeout_error <= 1'b0;
        end else begin
            if (r_state == DISPATCH) begin
                r_timeout_cnt <= '0;
            end else if (r_state == SERVICE) begin
                r_timeout_cnt <= r_timeout_cnt + 16'd1;
            end
            if (r_state == SERVICE && !handler_done && w_timeout_hit) begin
                r_timeout_error <= 1'b1;
            end
        end
    end
`else
    assign w_timeout_hit = 1'b0;
    assign timeout_error = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Handshake: vector_valid is high for the whole of DISPATCH with vector_id held;
    // the vector is taken on a cycle where vector_valid && vector_ready, and
    // vector_ready wins over a pending line dropping in that same cycle.
    always_comb begin
        w_next_state           = r_state;
        vector_valid           = 1'b0;
        service_busy           = 1'b1;
        clear_interrupt_select = '0;
        case (r_state)
            IDLE: begin
                service_busy = 1'b0;
                if (w_start) w_next_state = DISPATCH;
            end
            DISPATCH: begin
                vector_valid = 1'b1;
                if (vector_ready)        w_next_state = SERVICE;
                else if (!w_vec_pending) w_next_state = IDLE;
            end
            SERVICE: begin
                if (handler_done || w_timeout_hit) w_next_state = CLEAR;
            end
            CLEAR: begin
                clear_interrupt_select = NUM_INTERRUPTS'(1) << r_vector_id;
                w_next_state           = SETTLE;
            end
            SETTLE: begin
                if (r_settle_cnt == SETTLE_LAST) w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vector_id      <= '0;
            r_settle_cnt     <= '0;
            r_serviced_count <= '0;
        end else begin
            if (r_state == IDLE && w_start) begin
                r_vector_id <= highest_priority_int;
            end
            if (r_state == CLEAR) begin
                r_settle_cnt <= '0;
            end else if (r_state == SETTLE) begin
                r_settle_cnt <= r_settle_cnt + 2'd1;
            end
            if (r_state == CLEAR && r_serviced_count != 16'hFFFF) begin
                r_serviced_count <= r_serviced_count + 16'd1;
            end
        end
    end

    assign vector_id      = r_vector_id;
    assign serviced_count = r_serviced_count;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_interrupt_service_sequencer.sv
// Self-checking bench for interrupt_service_sequencer; clear pulses are scored
// against an expected-mask queue filled when each service is launched.
module tb_interrupt_service_sequencer;
    import isr_pkg::*;

`ifdef ISR_TIMEOUT_EN
    localparam int TIMEOUT = 10;
`else
    localparam int TIMEOUT = 255;
`endif

    logic        clock;
    logic        reset_n;
    logic        service_enable;
    logic        interrupt_request;
    logic [7:0]  interrupt_pending;
    logic [2:0]  highest_priority_int;
    logic        vector_valid;
    logic [2:0]  vector_id;
    logic        vector_ready;
    logic        handler_done;
    logic [7:0]  clear_interrupt_select;
    logic        service_busy;
    logic        timeout_error;
    logic [15:0] serviced_count;
    logic [2:0]  o_dbg_state;

    int          checks;
    int          failures;
    logic [15:0] exp_count;
    logic [7:0]  exp_q[$];

    interrupt_service_sequencer #(
        .NUM_INTERRUPTS(8),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .service_enable        (service_enable),
        .interrupt_request     (interrupt_request),
        .interrupt_pending     (interrupt_pending),
        .highest_priority_int  (highest_priority_int),
        .vector_valid          (vector_valid),
        .vector_id             (vector_id),
        .vector_ready          (vector_ready),
        .handler_done          (handler_done),
        .clear_interrupt_select(clear_interrupt_select),
        .service_busy          (service_busy),
        .timeout_error         (timeout_error),
        .serviced_count        (serviced_count),
        .o_dbg_state           (o_dbg_state)
    );

    // Clock / reset / watchdog
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired obs=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every clear pulse cycle must match the next expected mask.
    always @(negedge clock) begin
        if (reset_n && clear_interrupt_select != 8'h00) begin
            if (exp_q.size() == 0) begin
                check_eq("clr_unexpected", {24'h0, clear_interrupt_select}, 32'h0);
            end else begin
                check_eq("clr_mask", {24'h0, clear_interrupt_select}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic inc_count();
        if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    endtask

    task automatic wait_idle(input int max_cycles, output int n);
        n = 0;
        while (service_busy && n < max_cycles) begin
            tick();
            n++;
        end
    endtask

    // Full service: ready after ready_wait DISPATCH cycles, done after service_wait SERVICE cycles.
    task automatic run_service(input int id, input int ready_wait, input int service_wait,
                               input bit drop_enable);
        logic [7:0] m;
        int n;
        m = 8'h01 << id;
        service_enable       = 1'b1;
        interrupt_pending    = m;
        highest_priority_int = 3'(id);
        interrupt_request    = 1'b1;
        exp_q.push_back(m);
        tick();
        interrupt_request = 1'b0;
        check_eq("disp_valid", {31'h0, vector_valid}, 32'h1);
        check_eq("disp_id", {29'h0, vector_id}, id);
        handler_done = 1'b1;
        repeat (ready_wait) begin
            tick();
            check_eq("disp_hold_id", {29'h0, vector_id}, id);
        end
        handler_done = 1'b0;
        vector_ready = 1'b1;
        tick();
        vector_ready = 1'b0;
        check_eq("svc_valid", {31'h0, vector_valid}, 32'h0);
        check_eq("svc_busy", {31'h0, service_busy}, 32'h1);
        if (drop_enable) service_enable = 1'b0;
        repeat (service_wait) tick();
        handler_done = 1'b1;
        tick();
        handler_done      = 1'b0;
        interrupt_pending = 8'h00;
        inc_count();
        wait_idle(20, n);
        check_eq("settle_to_idle", n, 3);
        check_eq("count", {16'h0, serviced_count}, {16'h0, exp_count});
        service_enable = 1'b1;
    endtask

    initial begin
        int n;
        checks = 0;
        failures = 0;
        exp_count = 16'h0;
        reset_n = 1'b0;
        service_enable = 1'b0;
        interrupt_request = 1'b0;
        interrupt_pending = 8'h00;
        highest_priority_int = 3'd0;
        vector_ready = 1'b0;
        handler_done = 1'b0;
        repeat (3) tick();
        check_eq("rst_busy", {31'h0, service_busy}, 32'h0);
        check_eq("rst_valid", {31'h0, vector_valid}, 32'h0);
        check_eq("rst_count", {16'h0, serviced_count}, 32'h0);
        check_eq("rst_timeout", {31'h0, timeout_error}, 32'h0);
        check_eq("rst_state", {29'h0, o_dbg_state}, {29'h0, IDLE});
        reset_n = 1'b1;
        tick();

        // Prompt service of line 2: 5 busy cycles IDLE to IDLE
        run_service(2, 0, 0, 1'b0);

        // Start blocked by service_enable=0
        service_enable = 1'b0;
        interrupt_pending = 8'h10;
        highest_priority_int = 3'd4;
        interrupt_request = 1'b1;
        repeat (4) tick();
        check_eq("en_block_busy", {31'h0, service_busy}, 32'h0);
        // Request whose selected line is not pending
        service_enable = 1'b1;
        interrupt_pending = 8'h01;
        highest_priority_int = 3'd3;
        repeat (3) tick();
        check_eq("nopend_busy", {31'h0, service_busy}, 32'h0);
        interrupt_request = 1'b0;
        interrupt_pending = 8'h00;

        // Pending line 5 withdrawn during DISPATCH without ready
        interrupt_pending = 8'h20;
        highest_priority_int = 3'd5;
        interrupt_request = 1'b1;
        tick();
        check_eq("wd_disp_valid", {31'h0, vector_valid}, 32'h1);
        interrupt_pending = 8'h00;
        interrupt_request = 1'b0;
        tick();
        check_eq("wd_valid", {31'h0, vector_valid}, 32'h0);
        check_eq("wd_busy", {31'h0, service_busy}, 32'h0);
        check_eq("wd_count", {16'h0, serviced_count}, {16'h0, exp_count});

        // Ready wins over a withdrawal in the same cycle
        interrupt_pending = 8'h08;
        highest_priority_int = 3'd3;
        interrupt_request = 1'b1;
        exp_q.push_back(8'h08);
        tick();
        interrupt_request = 1'b0;
        interrupt_pending = 8'h00;
        vector_ready = 1'b1;
        tick();
        vector_ready = 1'b0;
        check_eq("prec_state", {29'h0, o_dbg_state}, {29'h0, SERVICE});
        handler_done = 1'b1;
        tick();
        handler_done = 1'b0;
        inc_count();
        wait_idle(20, n);
        check_eq("prec_idle", n, 3);
        check_eq("prec_count", {16'h0, serviced_count}, {16'h0, exp_count});

        // Enable dropped mid-SERVICE, with delayed ready and done
        run_service(7, 2, 3, 1'b1);

`ifdef ISR_TIMEOUT_EN
        // No handler_done: watchdog forces CLEAR after TIMEOUT SERVICE cycles
        interrupt_pending = 8'h02;
        highest_priority_int = 3'd1;
        interrupt_request = 1'b1;
        exp_q.push_back(8'h02);
        tick();
        interrupt_request = 1'b0;
        vector_ready = 1'b1;
        tick();
        vector_ready = 1'b0;
        check_eq("to_early", {31'h0, timeout_error}, 32'h0);
        n = 0;
        while (clear_interrupt_select == 8'h00 && n < 100) begin
            tick();
            n++;
        end
        check_eq("to_service_len", n, TIMEOUT);
        check_eq("to_flag", {31'h0, timeout_error}, 32'h1);
        interrupt_pending = 8'h00;
        inc_count();
        wait_idle(20, n);
        check_eq("to_count", {16'h0, serviced_count}, {16'h0, exp_count});
        check_eq("to_sticky", {31'h0, timeout_error}, 32'h1);
`else
        // Without the watchdog SERVICE waits indefinitely
        interrupt_pending = 8'h02;
        highest_priority_int = 3'd1;
        interrupt_request = 1'b1;
        exp_q.push_back(8'h02);
        tick();
        interrupt_request = 1'b0;
        vector_ready = 1'b1;
        tick();
        vector_ready = 1'b0;
        repeat (300) tick();
        check_eq("nto_state", {29'h0, o_dbg_state}, {29'h0, SERVICE});
        check_eq("nto_flag", {31'h0, timeout_error}, 32'h0);
        handler_done = 1'b1;
        tick();
        handler_done = 1'b0;
        interrupt_pending = 8'h00;
        inc_count();
        wait_idle(20, n);
        check_eq("nto_count", {16'h0, serviced_count}, {16'h0, exp_count});
`endif

        // Asynchronous reset in the middle of SERVICE
        interrupt_pending = 8'h40;
        highest_priority_int = 3'd6;
        interrupt_request = 1'b1;
        tick();
        interrupt_request = 1'b0;
        vector_ready = 1'b1;
        tick();
        vector_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("ar_busy", {31'h0, service_busy}, 32'h0);
        check_eq("ar_valid", {31'h0, vector_valid}, 32'h0);
        check_eq("ar_id", {29'h0, vector_id}, 32'h0);
        check_eq("ar_clear", {24'h0, clear_interrupt_select}, 32'h0);
        check_eq("ar_count", {16'h0, serviced_count}, 32'h0);
        check_eq("ar_timeout", {31'h0, timeout_error}, 32'h0);
        exp_count = 16'h0;
        interrupt_pending = 8'h00;
        handler_done = 1'b1;
        repeat (2) tick();
        handler_done = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) tick();
        check_eq("ar_after_state", {29'h0, o_dbg_state}, {29'h0, IDLE});

        // Randomised services
        for (int i = 0; i < 6; i++) begin
            run_service(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 4)), 1'b0);
        end

        // Saturation from a preloaded count
        #2;
        force dut.r_serviced_count = 16'hFFFD;
        #1;
        release dut.r_serviced_count;
        exp_count = 16'hFFFD;
        tick();
        check_eq("sat_preload", {16'h0, serviced_count}, {16'h0, exp_count});
        for (int i = 0; i < 3; i++) begin
            run_service(i, 0, 0, 1'b0);
        end
        check_eq("sat_hold", {16'h0, serviced_count}, 32'h0000FFFF);

        repeat (3) tick();
        check_eq("q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
